// File: rtl/commit_checker.sv
// commit_checker: checks the retire/writeback stream against buffered golden records.
// Define COMMIT_CHECK_FLOW_EN to add next-PC flow tracking (error code 7).
module commit_checker #(
  parameter int GOLD_DEPTH  = 8,
  parameter int WB_DEPTH    = 4,
  parameter int STOP_ON_ERR = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic [31:0] pc,
  input  logic [31:0] inst,
  input  logic        rdv,
  input  logic [4:0]  rd_m,
  input  logic [31:0] rd_data,
  input  logic        pcv,
  input  logic [31:0] pc_x,
  input  logic        exp_valid,
  output logic        exp_ready,
  input  logic [31:0] exp_pc,
  input  logic [31:0] exp_inst,
  input  logic        exp_rdv,
  input  logic [4:0]  exp_rd,
  input  logic [31:0] exp_rd_data,
  input  logic        exp_last,
  output logic        err,
  output logic [2:0]  err_code,
  output logic [31:0] err_pc,
  output logic [15:0] err_count,
  output logic [31:0] commit_count,
  output logic        done
);

  localparam int GW  = $clog2(GOLD_DEPTH);
  localparam int WW  = $clog2(WB_DEPTH);
  localparam int GRW = 103;
  localparam int WRW = 69;

  typedef enum logic [1:0] {
    S_IDLE, S_RUN, S_END, S_FAIL
  } state_e;

  state_e state_q, state_d;

  logic [GRW-1:0] gmem_q [GOLD_DEPTH];
  logic [WRW-1:0] wmem_q [WB_DEPTH];

  logic [GW-1:0] gwp_q, gwp_d, grp_q, grp_d;
  logic [GW:0]   gcnt_q, gcnt_d;
  logic [WW-1:0] wwp_q, wwp_d, wrp_q, wrp_d;
  logic [WW:0]   wcnt_q, wcnt_d;

  logic        err_q, err_d;
  logic [2:0]  err_code_q, err_code_d;
  logic [31:0] err_pc_q, err_pc_d;
  logic [15:0] err_count_q, err_count_d;
  logic [31:0] commit_count_q, commit_count_d;
  logic        done_q, done_d;

  logic        h_last, h_rdv;
  logic [4:0]  h_rd;
  logic [31:0] h_data, h_inst, h_pc;
  logic [4:0]  w_rd;
  logic [31:0] w_data, w_pc;

  logic gold_full, gold_empty, wb_full, wb_empty;
  logic active, chk;
  logic g_push, g_pop, w_pop, w_need, w_push;
  logic [7:1] e;
  logic any_err, stop_err, flow_err;
  logic [2:0] code;

  assign {h_last, h_rdv, h_rd, h_data, h_inst, h_pc} = gmem_q[grp_q];
  assign {w_rd, w_data, w_pc} = wmem_q[wrp_q];

  assign gold_full  = gcnt_q == (GW+1)'(GOLD_DEPTH);
  assign gold_empty = gcnt_q == '0;
  assign wb_full    = wcnt_q == (WW+1)'(WB_DEPTH);
  assign wb_empty   = wcnt_q == '0;

`ifdef COMMIT_CHECK_FLOW_EN
  logic [31:0] npc_q, npc_d;
  logic        npv_q, npv_d;

  // Latest redirect overrides the sequential successor.
  always_comb begin
    npc_d = npc_q;
    npv_d = npv_q;
    if (active) begin
      if (valid) begin
        npc_d = pcv ? pc_x : pc + 32'd4;
        npv_d = 1'b1;
      end else if (pcv) begin
        npc_d = pc_x;
      end
    end
  end

  assign flow_err = chk && valid && npv_q && (pc != npc_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      npc_q <= '0;
      npv_q <= 1'b0;
    end else begin
      npc_q <= npc_d;
      npv_q <= npv_d;
    end
  end
`else
  logic unused_flow;
  assign unused_flow = ^{pcv, pc_x};
  assign flow_err    = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (stop_err)              state_d = S_FAIL;
        else if (g_pop && h_last)  state_d = S_END;
        else if (g_push || valid)  state_d = S_RUN;
      end
      S_RUN: begin
        if (stop_err)              state_d = S_FAIL;
        else if (g_pop && h_last)  state_d = S_END;
      end
      S_END: begin
        if (stop_err)              state_d = S_FAIL;
      end
      default: ;
    endcase
  end

  always_comb begin
    active = 1'b1;
    chk    = 1'b0;
    unique case (state_q)
      S_IDLE, S_RUN: chk = 1'b1;
      S_FAIL:        active = 1'b0;
      default: ;
    endcase
  end

  assign exp_ready = !gold_full;

  // Writeback pop is evaluated before the retire push.
  always_comb begin
    g_push = active && (state_q != S_END) && exp_valid && !gold_full;
    g_pop  = chk && valid && !gold_empty;
    w_pop  = active && rdv && !wb_empty;
    w_need = g_pop && h_rdv && (h_rd != 5'd0);
    w_push = w_need && (!wb_full || w_pop);
    e      = '0;
    e[1]   = g_pop && (pc != h_pc);
    e[2]   = g_pop && (inst != h_inst);
    e[3]   = w_pop && ((rd_m != w_rd) || (rd_data != w_data));
    e[4]   = active && rdv && wb_empty;
    e[5]   = w_need && wb_full && !w_pop;
    e[6]   = valid && ((state_q == S_END) || (chk && gold_empty));
    e[7]   = flow_err;
    any_err  = |e;
    stop_err = any_err && (STOP_ON_ERR != 0);
    code = 3'd0;
    priority case (1'b1)
      e[1]:    code = 3'd1;
      e[2]:    code = 3'd2;
      e[3]:    code = 3'd3;
      e[4]:    code = 3'd4;
      e[5]:    code = 3'd5;
      e[6]:    code = 3'd6;
      e[7]:    code = 3'd7;
      default: code = 3'd0;
    endcase
  end

  always_comb begin
    gwp_d  = gwp_q + GW'(g_push);
    grp_d  = grp_q + GW'(g_pop);
    gcnt_d = gcnt_q + (GW+1)'(g_push) - (GW+1)'(g_pop);
    wwp_d  = wwp_q + WW'(w_push);
    wrp_d  = wrp_q + WW'(w_pop);
    wcnt_d = wcnt_q + (WW+1)'(w_push) - (WW+1)'(w_pop);
    err_d      = err_q | any_err;
    err_code_d = err_code_q;
    err_pc_d   = err_pc_q;
    if (any_err && !err_q) begin
      err_code_d = code;
      err_pc_d   = (code == 3'd3) ? w_pc : pc;
    end
    err_count_d = err_count_q;
    if (any_err && (err_count_q != 16'hFFFF)) begin
      err_count_d = err_count_q + 16'd1;
    end
    commit_count_d = commit_count_q + {31'd0, g_pop};
    done_d = (state_d == S_END) && (wcnt_d == '0) && !err_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gwp_q          <= '0;
      grp_q          <= '0;
      gcnt_q         <= '0;
      wwp_q          <= '0;
      wrp_q          <= '0;
      wcnt_q         <= '0;
      err_q          <= 1'b0;
      err_code_q     <= '0;
      err_pc_q       <= '0;
      err_count_q    <= '0;
      commit_count_q <= '0;
      done_q         <= 1'b0;
    end else begin
      gwp_q          <= gwp_d;
      grp_q          <= grp_d;
      gcnt_q         <= gcnt_d;
      wwp_q          <= wwp_d;
      wrp_q          <= wrp_d;
      wcnt_q         <= wcnt_d;
      err_q          <= err_d;
      err_code_q     <= err_code_d;
      err_pc_q       <= err_pc_d;
      err_count_q    <= err_count_d;
      commit_count_q <= commit_count_d;
      done_q         <= done_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < GOLD_DEPTH; i++) gmem_q[i] <= '0;
      for (int i = 0; i < WB_DEPTH; i++) wmem_q[i] <= '0;
    end else begin
      if (g_push) begin
        gmem_q[gwp_q] <= {exp_last, exp_rdv, exp_rd,
                          exp_rd_data, exp_inst, exp_pc};
      end
      if (w_push) begin
        wmem_q[wwp_q] <= {h_rd, h_data, h_pc};
      end
    end
  end

  assign err          = err_q;
  assign err_code     = err_code_q;
  assign err_pc       = err_pc_q;
  assign err_count    = err_count_q;
  assign commit_count = commit_count_q;
  assign done         = done_q;

endmodule

// File: tb/tb_commit_checker.sv
// tb_commit_checker: scoreboard bench with a queue-based reference model,
// directed scenarios plus randomized phases.
module tb_commit_checker;

  localparam int GD   = 8;
  localparam int WD   = 4;
  localparam int STOP = 1;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_END  = 2;
  localparam int M_FAIL = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid, rdv, pcv, exp_valid, exp_rdv, exp_last;
  logic [31:0] pc, inst, rd_data, pc_x, exp_pc, exp_inst, exp_rd_data;
  logic [4:0]  rd_m, exp_rd;
  logic        exp_ready, err, done;
  logic [2:0]  err_code;
  logic [31:0] err_pc, commit_count;
  logic [15:0] err_count;

  always #5 clk = ~clk;

  commit_checker #(
    .GOLD_DEPTH(GD), .WB_DEPTH(WD), .STOP_ON_ERR(STOP)
  ) dut (
    .clk(clk), .reset(reset),
    .valid(valid), .pc(pc), .inst(inst),
    .rdv(rdv), .rd_m(rd_m), .rd_data(rd_data),
    .pcv(pcv), .pc_x(pc_x),
    .exp_valid(exp_valid), .exp_ready(exp_ready),
    .exp_pc(exp_pc), .exp_inst(exp_inst), .exp_rdv(exp_rdv),
    .exp_rd(exp_rd), .exp_rd_data(exp_rd_data), .exp_last(exp_last),
    .err(err), .err_code(err_code), .err_pc(err_pc),
    .err_count(err_count), .commit_count(commit_count), .done(done)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        rdv;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        last;
  } gold_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] pc;
  } wb_t;

  typedef struct packed {
    logic        err;
    logic [2:0]  code;
    logic [31:0] epc;
    logic [15:0] ecnt;
    logic [31:0] ccnt;
    logic        done;
    logic        rdy;
  } exp_t;

  gold_t m_gold[$];
  wb_t   m_wb[$];
  exp_t  sb[$];
  int          m_mode;
  logic        m_err, m_done;
  logic [2:0]  m_code;
  logic [31:0] m_epc, m_ccnt, m_nxt;
  logic [15:0] m_ecnt;
  logic        m_nxt_v;

  int n_checks = 0;
  int n_err    = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", name, act, expv, $time);
    end
  endfunction

  always @(posedge clk) begin : monitor
    exp_t x;
    #1;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      chk("err", {31'd0, err}, {31'd0, x.err});
      chk("err_code", {29'd0, err_code}, {29'd0, x.code});
      chk("err_pc", err_pc, x.epc);
      chk("err_count", {16'd0, err_count}, {16'd0, x.ecnt});
      chk("commit_count", commit_count, x.ccnt);
      chk("done", {31'd0, done}, {31'd0, x.done});
      chk("exp_ready", {31'd0, exp_ready}, {31'd0, x.rdy});
    end
  end

  function automatic void push_exp();
    exp_t x;
    x.err  = m_err;
    x.code = m_code;
    x.epc  = m_epc;
    x.ecnt = m_ecnt;
    x.ccnt = m_ccnt;
    x.done = m_done;
    x.rdy  = (m_gold.size() < GD);
    sb.push_back(x);
  endfunction

  function automatic void model_reset();
    m_gold.delete();
    m_wb.delete();
    m_mode  = M_IDLE;
    m_err   = 1'b0;
    m_code  = '0;
    m_epc   = '0;
    m_ecnt  = '0;
    m_ccnt  = '0;
    m_done  = 1'b0;
    m_nxt   = '0;
    m_nxt_v = 1'b0;
  endfunction

  function automatic void model_step();
    logic [7:0]  ev;
    logic [31:0] p3;
    gold_t       h;
    wb_t         w;
    bit          push, need, endp;
    int          c;
    if (m_mode == M_FAIL) begin
      push_exp();
      return;
    end
    ev = '0; p3 = '0; need = 0; endp = 0; h = '0;
    push = exp_valid && (m_gold.size() < GD) && (m_mode != M_END);
    if (valid) begin
      if (m_mode == M_END || m_gold.size() == 0) begin
        ev[6] = 1'b1;
      end else begin
        h = m_gold.pop_front();
        if (h.pc != pc) ev[1] = 1'b1;
        if (h.inst != inst) ev[2] = 1'b1;
        m_ccnt++;
        endp = h.last;
        need = h.rdv && (h.rd != 0);
      end
    end
`ifdef COMMIT_CHECK_FLOW_EN
    if (valid && m_mode != M_END && m_nxt_v && pc != m_nxt) ev[7] = 1'b1;
    if (valid) begin
      m_nxt   = pcv ? pc_x : pc + 4;
      m_nxt_v = 1'b1;
    end else if (pcv) begin
      m_nxt = pc_x;
    end
`endif
    if (rdv) begin
      if (m_wb.size() == 0) begin
        ev[4] = 1'b1;
      end else begin
        w = m_wb.pop_front();
        if (w.rd != rd_m || w.data != rd_data) begin
          ev[3] = 1'b1;
          p3 = w.pc;
        end
      end
    end
    if (need) begin
      if (m_wb.size() == WD) ev[5] = 1'b1;
      else m_wb.push_back('{rd: h.rd, data: h.data, pc: h.pc});
    end
    if (push) begin
      m_gold.push_back('{pc: exp_pc, inst: exp_inst, rdv: exp_rdv,
                         rd: exp_rd, data: exp_rd_data, last: exp_last});
    end
    c = 0;
    for (int i = 7; i >= 1; i--) if (ev[i]) c = i;
    if (c != 0) begin
      if (m_ecnt != 16'hFFFF) m_ecnt++;
      if (!m_err) begin
        m_err  = 1'b1;
        m_code = 3'(c);
        m_epc  = (c == 3) ? p3 : pc;
      end
    end
    if (c != 0 && STOP != 0) m_mode = M_FAIL;
    else if (endp) m_mode = M_END;
    else if (m_mode == M_IDLE && (push || valid)) m_mode = M_RUN;
    m_done = (m_mode == M_END) && (m_wb.size() == 0) && !m_err;
    push_exp();
  endfunction

  task automatic set_idle();
    valid = 0; pc = '0; inst = '0;
    rdv = 0; rd_m = '0; rd_data = '0;
    pcv = 0; pc_x = '0;
    exp_valid = 0; exp_pc = '0; exp_inst = '0;
    exp_rdv = 0; exp_rd = '0; exp_rd_data = '0; exp_last = 0;
  endtask

  task automatic step();
    model_step();
    @(negedge clk);
    set_idle();
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1'b0;
    model_reset();
    push_exp();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic offer(logic [31:0] p, logic [31:0] i, logic rv,
                       logic [4:0] r, logic [31:0] d, logic l);
    exp_valid = 1; exp_pc = p; exp_inst = i;
    exp_rdv = rv; exp_rd = r; exp_rd_data = d; exp_last = l;
  endtask

  task automatic retire(logic [31:0] p, logic [31:0] i);
    valid = 1; pc = p; inst = i;
  endtask

  task automatic wback(logic [4:0] r, logic [31:0] d);
    rdv = 1; rd_m = r; rd_data = d;
  endtask

  task automatic run_phase();
    gold_t recs[$];
    gold_t g;
    int k, idx, cyc;
    logic [31:0] base;
    k = $urandom_range(1, 16);
    base = $urandom & 32'hFFFF_FFFC;
    for (int i = 0; i < k; i++) begin
      g.pc   = base + 32'(4 * i);
      g.inst = $urandom;
      g.rdv  = 1'($urandom_range(0, 1));
      g.rd   = 5'($urandom_range(0, 31));
      g.data = $urandom;
      g.last = (i == k - 1);
      recs.push_back(g);
    end
    do_reset();
    idx = 0;
    cyc = 0;
    while (cyc < 200 && m_mode != M_FAIL && !m_done) begin
      if (idx < k && $urandom_range(0, 2) != 0) begin
        offer(recs[idx].pc, recs[idx].inst, recs[idx].rdv,
              recs[idx].rd, recs[idx].data, recs[idx].last);
        if (m_gold.size() < GD && m_mode != M_END) idx++;
      end
      if (m_gold.size() > 0 && $urandom_range(0, 1) == 0) begin
        retire(m_gold[0].pc, m_gold[0].inst);
        if ($urandom_range(0, 39) == 0) pc = pc ^ 32'h10;
        if ($urandom_range(0, 39) == 0) inst = inst ^ 32'h1;
      end else if ($urandom_range(0, 59) == 0) begin
        retire($urandom & 32'hFFFF_FFFC, $urandom);
      end
      if (m_wb.size() > 0 && ($urandom_range(0, 1) == 0 || m_wb.size() >= 3)) begin
        wback(m_wb[0].rd, m_wb[0].data);
        if ($urandom_range(0, 39) == 0) rd_data = rd_data + 1;
      end else if ($urandom_range(0, 79) == 0) begin
        wback(5'($urandom_range(0, 31)), $urandom);
      end
      step();
      cyc++;
    end
    step();
    step();
  endtask

  initial begin
    set_idle();
    reset = 1'b0;

    // normal flow: three addi records, writeback after each retire
    do_reset();
    offer(32'h0, 32'h00100093, 1, 5'd1, 32'd1, 0); step();
    offer(32'h4, 32'h00200113, 1, 5'd2, 32'd2, 0); step();
    offer(32'h8, 32'h00300193, 1, 5'd3, 32'd3, 1); step();
    retire(32'h0, 32'h00100093); step();
    wback(5'd1, 32'd1); step();
    retire(32'h4, 32'h00200113); step();
    wback(5'd2, 32'd2); step();
    retire(32'h8, 32'h00300193); step();
    chk("t1_done_pending", {31'd0, done}, 32'd0);
    wback(5'd3, 32'd3); step();
    chk("t1_err", {31'd0, err}, 32'd0);
    chk("t1_commit", commit_count, 32'd3);
    chk("t1_done", {31'd0, done}, 32'd1);

    // pc mismatch then frozen
    do_reset();
    offer(32'h100, 32'h13, 0, 5'd0, 32'd0, 0); step();
    retire(32'h104, 32'h13); step();
    chk("t2_err", {31'd0, err}, 32'd1);
    chk("t2_code", {29'd0, err_code}, 32'd1);
    chk("t2_pc", err_pc, 32'h104);
    chk("t2_cnt", {16'd0, err_count}, 32'd1);
    offer(32'h200, 32'h13, 0, 5'd0, 32'd0, 0); step();
    retire(32'h300, 32'h0); step();
    chk("t2_cnt_frozen", {16'd0, err_count}, 32'd1);

    // writeback data mismatch
    do_reset();
    offer(32'h20, 32'h05500293, 1, 5'd5, 32'h55, 0); step();
    retire(32'h20, 32'h05500293); step();
    wback(5'd5, 32'h56); step();
    chk("t3_code", {29'd0, err_code}, 32'd3);
    chk("t3_pc", err_pc, 32'h20);

    // spurious writeback, underrun
    do_reset();
    wback(5'd1, 32'd0); step();
    chk("t4_spurious", {29'd0, err_code}, 32'd4);
    do_reset();
    retire(32'h0, 32'h13); step();
    chk("t4_underrun", {29'd0, err_code}, 32'd6);

    // writeback queue overflow on the fifth writing retire
    do_reset();
    for (int i = 0; i < 5; i++) begin
      offer(32'h200 + 32'(4 * i), 32'h13, 1, 5'(i + 1), 32'(i), 0);
      step();
    end
    for (int i = 0; i < 5; i++) begin
      retire(32'h200 + 32'(4 * i), 32'h13);
      step();
    end
    chk("t5_code", {29'd0, err_code}, 32'd5);
    chk("t5_pc", err_pc, 32'h210);

    // golden buffer full back-pressure
    do_reset();
    for (int i = 0; i < GD; i++) begin
      offer(32'h400 + 32'(4 * i), 32'h13, 0, 5'd0, 32'd0, 0);
      step();
    end
    chk("t6_full", {31'd0, exp_ready}, 32'd0);
    offer(32'h800, 32'h13, 0, 5'd0, 32'd0, 0); step();
    chk("t6_still_full", {31'd0, exp_ready}, 32'd0);
    retire(32'h400, 32'h13); step();
    chk("t6_ready", {31'd0, exp_ready}, 32'd1);
    chk("t6_err", {31'd0, err}, 32'd0);

`ifdef COMMIT_CHECK_FLOW_EN
    do_reset();
    offer(32'h0, 32'h13, 0, 5'd0, 32'd0, 0); step();
    offer(32'h4, 32'h13, 0, 5'd0, 32'd0, 0); step();
    retire(32'h0, 32'h13); step();
    pcv = 1; pc_x = 32'h40; step();
    retire(32'h4, 32'h13); step();
    chk("t7_flow", {29'd0, err_code}, 32'd7);
    do_reset();
    offer(32'h0, 32'h13, 0, 5'd0, 32'd0, 0); step();
    offer(32'h40, 32'h13, 0, 5'd0, 32'd0, 0); step();
    retire(32'h0, 32'h13); step();
    pcv = 1; pc_x = 32'h40; step();
    retire(32'h40, 32'h13); step();
    chk("t7_redirect_ok", {31'd0, err}, 32'd0);
`endif

    for (int p = 0; p < 60; p++) run_phase();

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: %0d entries left, want 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
